// File: rtl/demux_pkg.sv
// Shared types and constants for the 1:4 lane demultiplexer.
package demux_pkg;

   localparam int unsigned NUM_LANES  = 4;
   localparam int unsigned LANE_PTR_W = 2;
   localparam int unsigned IDLE_CNT_W = 4;

   typedef enum logic [0:0] {
      ST_EMPTY = 1'b0,
      ST_FILL  = 1'b1
   } state_e;

   typedef logic [LANE_PTR_W-1:0] lane_ptr_t;

   // True when the pointer addresses the final lane of a frame.
   function automatic logic is_last_lane(input lane_ptr_t ptr);
      return ptr == LANE_PTR_W'(NUM_LANES - 1);
   endfunction

endpackage

// File: rtl/demux_idle_timer.sv
// Mid-frame idle counter; timeout is asserted combinationally on the idle
// cycle that would bring the count to IDLE_MAX.
module demux_idle_timer
   import demux_pkg::*;
#(
   parameter int unsigned IDLE_MAX = 3
) (
   input  logic clk_4f,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic timeout
);

   logic [IDLE_CNT_W-1:0] cnt;

   assign timeout = enable && !clear && (cnt == IDLE_CNT_W'(IDLE_MAX - 1));

   always_ff @(posedge clk_4f or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (clear || timeout) begin
         cnt <= '0;
      end else if (enable) begin
         cnt <= cnt + IDLE_CNT_W'(1);
      end
   end

endmodule

// File: rtl/demux1a4_cond.sv
// Serial-to-parallel 1:4 demux with idle-timeout abandonment of partial frames.
// Define DEMUX_PARTIAL_FLUSH_EN to flush held lanes on timeout instead of dropping them.
module demux1a4_cond
   import demux_pkg::*;
#(
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned IDLE_MAX = 3
) (
   input  logic              clk_4f,
   input  logic              reset,
   input  logic              valid_in,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out0,
   output logic [DATA_W-1:0] data_out1,
   output logic [DATA_W-1:0] data_out2,
   output logic [DATA_W-1:0] data_out3,
   output logic              validout0,
   output logic              validout1,
   output logic              validout2,
   output logic              validout3,
   output logic              frame_valid,
   output logic              err_partial
);

   state_e                state, state_nx;
   lane_ptr_t             ptr, ptr_nx;
   logic [NUM_LANES-1:0]  mask, mask_nx;
   logic [DATA_W-1:0]     hold     [NUM_LANES];
   logic [DATA_W-1:0]     hold_nx  [NUM_LANES];
   logic [DATA_W-1:0]     dout_q   [NUM_LANES];
   logic [DATA_W-1:0]     dout_nx  [NUM_LANES];
   logic [NUM_LANES-1:0]  vout_q, vout_nx;
   logic                  fv_q, fv_nx;
   logic                  err_q, err_nx;
   logic                  timer_clear;
   logic                  timer_enable;
   logic                  timeout;

   // Counter only runs while a frame is partially filled and no byte arrives,
   // so a byte on the would-be timeout cycle always wins.
   assign timer_clear  = valid_in || (state == ST_EMPTY);
   assign timer_enable = (state == ST_FILL) && !valid_in;

   demux_idle_timer #(
      .IDLE_MAX (IDLE_MAX)
   ) u_idle_timer (
      .clk_4f  (clk_4f),
      .reset   (reset),
      .clear   (timer_clear),
      .enable  (timer_enable),
      .timeout (timeout)
   );

   always_ff @(posedge clk_4f or posedge reset) begin
      if (reset) begin
         state  <= ST_EMPTY;
         ptr    <= '0;
         mask   <= '0;
         vout_q <= '0;
         fv_q   <= 1'b0;
         err_q  <= 1'b0;
         for (int i = 0; i < NUM_LANES; i++) begin
            hold[i]   <= '0;
            dout_q[i] <= '0;
         end
      end else begin
         state  <= state_nx;
         ptr    <= ptr_nx;
         mask   <= mask_nx;
         vout_q <= vout_nx;
         fv_q   <= fv_nx;
         err_q  <= err_nx;
         for (int i = 0; i < NUM_LANES; i++) begin
            hold[i]   <= hold_nx[i];
            dout_q[i] <= dout_nx[i];
         end
      end
   end

   always_comb begin
      state_nx = state;
      ptr_nx   = ptr;
      mask_nx  = mask;
      hold_nx  = hold;
      dout_nx  = dout_q;
      vout_nx  = '0;
      fv_nx    = 1'b0;
      err_nx   = 1'b0;

      if (valid_in) begin
         hold_nx[ptr] = data_in;
         mask_nx[ptr] = 1'b1;
         ptr_nx       = ptr + LANE_PTR_W'(1);
         state_nx     = ST_FILL;
         if (is_last_lane(ptr)) begin
            // Lane 3 bypasses its hold register so delivery costs one cycle.
            for (int i = 0; i < NUM_LANES - 1; i++) begin
               dout_nx[i] = hold[i];
            end
            dout_nx[NUM_LANES-1] = data_in;
            vout_nx  = '1;
            fv_nx    = 1'b1;
            mask_nx  = '0;
            state_nx = ST_EMPTY;
         end
      end else if (timeout) begin
         err_nx   = 1'b1;
         ptr_nx   = '0;
         mask_nx  = '0;
         state_nx = ST_EMPTY;
`ifdef DEMUX_PARTIAL_FLUSH_EN
         for (int i = 0; i < NUM_LANES; i++) begin
            if (mask[i]) begin
               dout_nx[i] = hold[i];
            end
         end
         vout_nx = mask;
`endif
      end
   end

   assign data_out0   = dout_q[0];
   assign data_out1   = dout_q[1];
   assign data_out2   = dout_q[2];
   assign data_out3   = dout_q[3];
   assign validout0   = vout_q[0];
   assign validout1   = vout_q[1];
   assign validout2   = vout_q[2];
   assign validout3   = vout_q[3];
   assign frame_valid = fv_q;
   assign err_partial = err_q;

endmodule
